ssvga_dpram_arb: RTL and testbench

SSVGA_DPRAM_ARB -- requirements
Module: ssvga_dpram_arb

---
 rtl/ssvga_dpram_arb.sv | 113 +++++++++++
 tb/tb_ssvga_dpram_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssvga_dpram_arb.sv
// rtl/ssvga_dpram_arb.sv - two-requester arbiter in front of a single RAM port (IDLE/ACCESS/RESP)
// Optional SSVGA_DPRAM_ARB_RR_EN: round-robin on simultaneous requests instead of fixed r0 priority.
module ssvga_dpram_arb #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clka,
  input  logic          rstb,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r0_ack,
  output logic          r1_ack,
  output logic [DW-1:0] rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic          ram_rst,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          win;
  logic          win_nxt;
  logic          last_grant;
  logic          last_grant_nxt;
  logic          any_req;
  logic          sel;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  always_comb begin
    any_req = r0_req | r1_req;
    sel     = 1'b0;
    if (r0_req && r1_req) begin
`ifdef SSVGA_DPRAM_ARB_RR_EN
      sel = ~last_grant;
`else
      sel = 1'b0;
`endif
    end else begin
      sel = r1_req;
    end
  end

  always_comb begin
    state_nxt      = state;
    win_nxt        = win;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt      = ACCESS;
          win_nxt        = sel;
          last_grant_nxt = sel;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner's command is captured at grant so a requester dropping req mid-access cannot corrupt it.
  always_ff @(posedge clka) begin
    if (rstb) begin
      state      <= IDLE;
      win        <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      win        <= win_nxt;
      last_grant <= last_grant_nxt;
      if (state == IDLE && any_req) begin
        lat_we    <= sel ? r1_we    : r0_we;
        lat_addr  <= sel ? r1_addr  : r0_addr;
        lat_wdata <= sel ? r1_wdata : r0_wdata;
      end
    end
  end

  always_comb begin
    ram_rst  = 1'b0;
    ram_en   = (state == ACCESS);
    ram_we   = ram_en & lat_we;
    ram_addr = ram_en ? lat_addr : '0;
    ram_di   = ram_en ? lat_wdata : '0;
    r0_ack   = (state == RESP) && !win;
    r1_ack   = (state == RESP) && win;
    rdata    = '0;
    if (state == RESP) begin
      rdata = lat_we ? lat_wdata : ram_do;
    end
  end

endmodule

// File: tb/tb_ssvga_dpram_arb.sv
// tb/tb_ssvga_dpram_arb.sv - randomized scoreboard bench for ssvga_dpram_arb with behavioural RAM and arbitration model
module tb_ssvga_dpram_arb;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clka = 1'b0;
  logic          rstb = 1'b1;
  logic          r0_req = 1'b0, r0_we = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r0_ack, r1_ack, ram_en, ram_we, ram_rst;
  logic [DW-1:0] rdata, ram_di;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_do = '0;

  ssvga_dpram_arb #(.AW(AW), .DW(DW)) dut (
    .clka(clka), .rstb(rstb),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_ack(r0_ack), .r1_ack(r1_ack), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_rst(ram_rst),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 clka = ~clka;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'hFF) ? 16'h5A5A : ({a, ~a} ^ 16'h3C3C);
  endfunction

  // RAM port A: registered read, unwritten locations return their preload value
  logic [15:0]  ram_mem [256];
  logic [255:0] ram_wr = '0;
  always @(posedge clka) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_di;
        ram_wr[ram_addr]  <= 1'b1;
      end else begin
        ram_do <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
      end
    end
  end

  typedef struct {
    int          who;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          ack_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        awaiting = 1'b0;
  logic [15:0] ref_mem [256];
  logic        lg_model = 1'b1;

  task automatic push(input int who, input logic we, input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    e.who = who; e.we = we; e.addr = a; e.wdata = d;
    e.rdata = we ? d : ref_mem[a];
    if (we) ref_mem[a] = d;
    lg_model = (who != 0);
    exp_q.push_back(e);
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic drive(input int who, input logic req, input logic we, input logic [7:0] a, input logic [15:0] d);
    if (who == 0) begin
      r0_we = we; r0_addr = a; r0_wdata = d; r0_req = req;
    end else begin
      r1_we = we; r1_addr = a; r1_wdata = d; r1_req = req;
    end
  endtask

  task automatic drop(input int who);
    if (who == 0) r0_req = 1'b0;
    else r1_req = 1'b0;
  endtask

  // mode 0: drop req after ack, 1: keep req high for a follow-on txn, 2: drop req during ACCESS
  task automatic run(input int who, input logic we, input logic [7:0] a, input logic [15:0] d,
                     input int mode, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    drive(who, 1'b1, we, a, d);
    for (int i = 0; i < 64; i++) begin
      @(posedge clka); #1;
      lat++;
      if ((who == 0) ? r0_ack : r1_ack) begin
        got = 1'b1;
        break;
      end
      if (mode == 2 && lat == 1) begin
        @(negedge clka);
        drop(who);
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: requester %0d got no ack in 64 cycles, required an ack", who);
    end
    @(negedge clka);
    if (mode != 1) drop(who);
  endtask

  task automatic single(input int who, input logic we, input logic [7:0] a, input logic [15:0] d,
                        input int mode, input string name);
    int lat;
    push(who, we, a, d);
    run(who, we, a, d, mode, lat);
    chk_int(name, lat, 2);
    @(negedge clka);
  endtask

  task automatic burst(input int n0, input int n1);
    logic        we0 [4], we1 [4];
    logic [7:0]  a0 [4], a1 [4];
    logic [15:0] d0 [4], d1 [4];
    int          i0, i1, w;
    for (int k = 0; k < 4; k++) begin
      we0[k] = 1'($urandom_range(0, 1)); we1[k] = 1'($urandom_range(0, 1));
      a0[k]  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      a1[k]  = 8'($urandom_range(0, 7));
      d0[k]  = 16'($urandom); d1[k] = 16'($urandom);
    end
    i0 = 0; i1 = 0;
    while (i0 < n0 || i1 < n1) begin
      if (i0 < n0 && i1 < n1) begin
`ifdef SSVGA_DPRAM_ARB_RR_EN
        w = lg_model ? 0 : 1;
`else
        w = 0;
`endif
      end else begin
        w = (i0 < n0) ? 0 : 1;
      end
      if (w == 0) begin
        push(0, we0[i0], a0[i0], d0[i0]); i0++;
      end else begin
        push(1, we1[i1], a1[i1], d1[i1]); i1++;
      end
    end
    fork
      begin
        int l0;
        for (int k = 0; k < n0; k++) run(0, we0[k], a0[k], d0[k], (k < n0 - 1) ? 1 : 0, l0);
      end
      begin
        int l1;
        for (int k = 0; k < n1; k++) run(1, we1[k], a1[k], d1[k], (k < n1 - 1) ? 1 : 0, l1);
      end
    join
  endtask

  task automatic chk_spacing(input string name);
    for (int i = 1; i < ack_cyc.size(); i++) chk_int(name, ack_cyc[i] - ack_cyc[i-1], 3);
  endtask

  // Monitor: pops the expected entry at each RAM access, checks the ack one cycle later
  initial begin
    forever begin
      @(posedge clka); #1;
      cyc++;
      if (rstb) begin
        checks++;
        if (r0_ack || r1_ack || ram_en || ram_we || ram_rst || ram_addr != '0 || ram_di != '0 || rdata != '0) begin
          errors++;
          $display("FAIL reset_outputs: ack=%b%b en=%b we=%b addr=%h di=%h rdata=%h, required all 0",
                   r0_ack, r1_ack, ram_en, ram_we, ram_addr, ram_di, rdata);
        end
        awaiting = 1'b0;
      end else begin
        checks++;
        if (awaiting) begin
          if (((cur.who == 0) ? !(r0_ack && !r1_ack) : !(r1_ack && !r0_ack)) || rdata !== cur.rdata) begin
            errors++;
            $display("FAIL ack_resp: r0_ack=%b r1_ack=%b rdata=%h, required ack for r%0d rdata=%h",
                     r0_ack, r1_ack, rdata, cur.who, cur.rdata);
          end
          ack_cyc.push_back(cyc);
          awaiting = 1'b0;
        end else if (r0_ack || r1_ack) begin
          errors++;
          $display("FAIL stray_ack: r0_ack=%b r1_ack=%b with no preceding access, required 0", r0_ack, r1_ack);
        end
        checks++;
        if (ram_en) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_access: ram_en=1 addr=%h, required no access", ram_addr);
          end else begin
            cur = exp_q.pop_front();
            if (ram_we !== cur.we || ram_addr !== cur.addr || ram_di !== cur.wdata) begin
              errors++;
              $display("FAIL access: we=%b addr=%h di=%h, required we=%b addr=%h di=%h",
                       ram_we, ram_addr, ram_di, cur.we, cur.addr, cur.wdata);
            end
            awaiting = 1'b1;
          end
        end else if (ram_we || ram_addr != '0 || ram_di != '0 || ram_rst) begin
          errors++;
          $display("FAIL idle_port: we=%b addr=%h di=%h rst=%b, required all 0", ram_we, ram_addr, ram_di, ram_rst);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i[7:0]);
    rstb = 1'b1;
    repeat (3) @(negedge clka);
    rstb = 1'b0;
    lg_model = 1'b1;

    single(0, 1'b1, 8'h12, 16'hBEEF, 0, "r0_write_latency");
    single(0, 1'b0, 8'h12, 16'h0000, 0, "r0_read_latency");
    single(1, 1'b0, 8'hFF, 16'h0000, 0, "r1_read_max_latency");

    ack_cyc.delete();
    burst(2, 2);
    chk_spacing("both_req_spacing");
    @(negedge clka);
    ack_cyc.delete();
    burst(4, 1);
    chk_spacing("r0_hold_spacing");
    @(negedge clka);

    // reset pulsed while an r1 write is in ACCESS
    push(1, 1'b1, 8'h40, 16'h1234);
    drive(1, 1'b1, 1'b1, 8'h40, 16'h1234);
    @(posedge clka);
    @(negedge clka);
    rstb = 1'b1;
    @(posedge clka);
    @(negedge clka);
    rstb = 1'b0;
    drop(1);
    lg_model = 1'b1;
    repeat (3) @(negedge clka);
    single(0, 1'b0, 8'h40, 16'h0000, 0, "after_reset_latency");

    single(0, 1'b0, 8'h05, 16'h0000, 2, "early_drop_latency");
    repeat (4) @(negedge clka);

    for (int t = 0; t < 25; t++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      burst(n0, n1);
      repeat ($urandom_range(0, 2)) @(negedge clka);
    end

    for (int i = 0; i < 20 && (exp_q.size() != 0 || awaiting); i++) @(negedge clka);
    chk_int("pending_expected", exp_q.size() + (awaiting ? 1 : 0), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
